// File: rtl/dspmod_tgt_sched.sv
// Round-robin target scheduler for the MASH modulator; applies goals on frame ticks.
// Optional DSPMOD_TGT_PREEMPT_EN lets req0 replace the goal during a ramp.
module dspmod_tgt_sched #(
  parameter int          FRAME_LEN    = 64,
  parameter logic [31:0] RESET_TARGET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_target,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_target,
  output logic        req1_ready,
  input  logic [31:0] step,
  output logic [31:0] target,
  output logic        frame_tick,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [16:0] LAST = 17'(FRAME_LEN - 1);

  state_t      state;
  logic [16:0] cnt;
  logic [16:0] cnt_nxt;
  logic [31:0] goal;
  logic        up;
  logic [32:0] diff;
  logic        done;

  assign busy    = (state == RAMP);
  assign cnt_nxt = (cnt == LAST) ? 17'd0 : cnt + 17'd1;
  assign up      = goal > target;
  assign diff    = up ? ({1'b0, goal} - {1'b0, target})
                      : ({1'b0, target} - {1'b0, goal});
  assign done    = (step == 32'd0) || (diff <= {1'b0, step});

  // The loser of the last contest wins a tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        req0_ready = req0_valid && (!req1_valid || grant_id);
        req1_ready = req1_valid && (!req0_valid || !grant_id);
      end
`ifdef DSPMOD_TGT_PREEMPT_EN
      else begin
        req0_ready = req0_valid;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 17'd0;
      frame_tick <= 1'b0;
      target     <= RESET_TARGET;
      goal       <= RESET_TARGET;
      grant_id   <= 1'b1;
    end else begin
      cnt        <= cnt_nxt;
      frame_tick <= (cnt_nxt == LAST);
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            goal     <= req0_ready ? req0_target : req1_target;
            grant_id <= req1_ready;
            state    <= RAMP;
          end
        end
        RAMP: begin
          if (frame_tick) begin
            if (done) begin
              target <= goal;
              state  <= IDLE;
            end else if (up) begin
              target <= target + step;
            end else begin
              target <= target - step;
            end
          end
          // A preempting goal only takes effect from the next tick.
          if (req0_ready) begin
            goal     <= req0_target;
            grant_id <= 1'b0;
            state    <= RAMP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dspmod_tgt_sched.sv
// Scoreboard bench for dspmod_tgt_sched with a behavioural model.
// Directed test-plan scenarios followed by randomized traffic.
module tb_dspmod_tgt_sched;

  localparam int          FL = 8;
  localparam logic [31:0] RT = 32'd100;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic [31:0] t0, t1;
  logic        r0, r1;
  logic [31:0] stp;
  logic [31:0] target;
  logic        frame_tick;
  logic        busy;
  logic        grant_id;

  dspmod_tgt_sched #(.FRAME_LEN(FL), .RESET_TARGET(RT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_target(t0), .req0_ready(r0),
    .req1_valid(v1), .req1_target(t1), .req1_ready(r1),
    .step(stp), .target(target), .frame_tick(frame_tick),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] t;
    logic        b;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_target, m_goal;
  logic        m_busy, m_gid;
  int          m_cnt;
  logic        acc0, acc1;
  logic        mon_pend;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=done t=%0t", name, $time);
  endtask

  function automatic void exp_rdy(output logic e0, output logic e1);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      e0 = v0 && (!v1 || m_gid);
      e1 = v1 && (!v0 || !m_gid);
    end else begin
`ifdef DSPMOD_TGT_PREEMPT_EN
      e0 = v0;
`endif
    end
  endfunction

  task automatic model_step();
    logic   e0, e1, tick;
    longint d;
    exp_t   e;
    exp_rdy(e0, e1);
    acc0 = e0;
    acc1 = e1;
    tick = (m_cnt == FL - 1);
    if (!m_busy) begin
      if (e0) begin
        m_goal = t0; m_gid = 1'b0; m_busy = 1'b1;
      end else if (e1) begin
        m_goal = t1; m_gid = 1'b1; m_busy = 1'b1;
      end
    end else begin
      if (tick) begin
        if (m_goal > m_target) d = {32'd0, m_goal} - {32'd0, m_target};
        else d = {32'd0, m_target} - {32'd0, m_goal};
        if (stp == 0 || d <= {32'd0, stp}) begin
          m_target = m_goal;
          m_busy   = 1'b0;
        end else if (m_goal > m_target) begin
          m_target = m_target + stp;
        end else begin
          m_target = m_target - stp;
        end
      end
      if (e0) begin
        m_goal = t0; m_gid = 1'b0; m_busy = 1'b1;
      end
      if (tick) begin
        e.t = m_target;
        e.b = m_busy;
        q.push_back(e);
      end
    end
    m_cnt = (m_cnt + 1) % FL;
  endtask

  // Scoreboard monitor: each tick seen while busy must match a queued update.
  initial begin
    exp_t e;
    mon_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=update required=none t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_target", target, e.t);
          chk("sb_busy", busy, e.b);
        end
      end
      mon_pend = frame_tick && busy && !rst;
    end
  end

  task automatic cycle();
    logic e0, e1;
    #1;
    exp_rdy(e0, e1);
    chk("ready", {r1, r0}, {e1, e0});
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    chk("target", target, m_target);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("frame_tick", frame_tick, m_cnt == FL - 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m_cnt    = 0;
    m_target = RT;
    m_goal   = RT;
    m_busy   = 1'b0;
    m_gid    = 1'b1;
    acc0     = 1'b0;
    acc1     = 1'b0;
    q.delete();
    mon_pend = 1'b0;
    #1;
    chk("rst_target", target, RT);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {r1, r0}, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("rst_gid", grant_id, 1);
    chk("rst_tick", frame_tick, 0);
  endtask

  task automatic send(input int id, input logic [31:0] val);
    bit ok = 0;
    if (id == 0) begin v0 = 1'b1; t0 = val; end
    else begin v1 = 1'b1; t1 = val; end
    for (int i = 0; i < 200; i++) begin
      cycle();
      if ((id == 0) ? acc0 : acc1) begin ok = 1; break; end
    end
    if (!ok) timeout("send");
    if (id == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_busy; i++) cycle();
    if (m_busy) timeout("wait_idle");
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 3)
      0: return $urandom;
      1: return $urandom_range(0, 5000);
      default: return 32'hFFFF_FFFF - $urandom_range(0, 5000);
    endcase
  endfunction

  function automatic logic [31:0] rnd_step();
    case ($urandom % 4)
      0: return 32'd0;
      1: return $urandom_range(1, 3000);
      2: return $urandom;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    t0 = '0; t1 = '0;
    stp = '0;
    @(negedge clk);
    do_reset();
    chk("init_target", target, 100);
    repeat (20) cycle();

    // Ramp up 100 -> 3500, then down to 0.
    stp = 32'd1000;
    send(1, 32'd3500);
    wait_idle();
    chk("ramp_up_end", target, 3500);
    stp = 32'd1500;
    send(0, 32'd0);
    wait_idle();
    chk("ramp_dn_end", target, 0);

    // Jump.
    repeat (3) cycle();
    stp = 32'd0;
    send(0, 32'd5000);
    wait_idle();
    chk("jump_end", target, 5000);

    // Equal goal: no change, back to idle.
    send(1, 32'd5000);
    wait_idle();

    // Round-robin contention.
    v0 = 1'b1; t0 = 32'd10;
    v1 = 1'b1; t1 = 32'd20;
    repeat (60) cycle();
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Reset in the middle of a ramp.
    @(negedge clk);
    do_reset();
    stp = 32'd1000;
    send(1, 32'd3500);
    for (int i = 0; i < 12; i++) cycle();
    do_reset();
    chk("midrst_target", target, 100);
    repeat (20) cycle();

`ifdef DSPMOD_TGT_PREEMPT_EN
    stp = 32'd0;
    send(0, 32'd0);
    wait_idle();
    stp = 32'd1000;
    send(1, 32'd10000);
    v1 = 1'b1;
    for (int i = 0; i < 200 && m_target != 32'd3000; i++) cycle();
    if (m_target != 32'd3000) timeout("reach_3000");
    send(0, 32'd1000);
    wait_idle();
    v1 = 1'b0;
    chk("preempt_end", target, 1000);
    repeat (10) cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom % 3 == 0);
        t0 = rnd32();
      end
      if (!v1 || acc1) begin
        v1 = ($urandom % 3 == 0);
        t1 = rnd32();
      end
      if ($urandom % 16 == 0) stp = rnd_step();
      cycle();
    end
    v0 = 1'b0; v1 = 1'b0;
    stp = 32'd0;
    wait_idle();
    repeat (2) cycle();
    chk("sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dspmod_tgt_sched.md
Name: dspmod_tgt_sched

Overview:
- Schedules and arbitrates 32-bit target updates for the MASH delta-sigma modulator chain.
- Two requesters compete for the single modulator target, arbitrated round-robin.
- An accepted target is applied only on PWM frame boundaries, either as an immediate jump or as a bounded-step slew.
- The `target` output drives the modulator's 32-bit target input directly; `frame_tick` is exported for frame-aligned logic elsewhere.

Parameters:
- FRAME_LEN, 64, clocks per modulator frame; legal range 2..65536.
- RESET_TARGET, 32'h0000_0000, value of `target` during and after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req0_valid  input  1  requester 0 has a target pending.
- req0_target  input  32  requester 0 goal value.
- req0_ready  output  1  requester 0 handshake accept.
- req1_valid  input  1  requester 1 has a target pending.
- req1_target  input  32  requester 1 goal value.
- req1_ready  output  1  requester 1 handshake accept.
- step  input  32  slew per frame; 0 means jump directly to goal.
- target  output  32  registered target to the modulator.
- frame_tick  output  1  registered; high for 1 clk when frame counter = FRAME_LEN-1.
- busy  output  1  high when state is not IDLE.
- grant_id  output  1  index of the last accepted requester.

Behaviour:
- Reset, asynchronous, active-high. While rst=1 and after release:
  - state=IDLE, frame counter=0, frame_tick=0, target=RESET_TARGET, goal=RESET_TARGET.
  - grant_id=1, so req0 wins the first contest; busy=0; both ready=0.
- Reset mid-ramp abandons the goal; `target` returns to RESET_TARGET immediately.
- Frame counter:
  - Free-running 0..FRAME_LEN-1, wraps to 0; unaffected by the FSM.
  - frame_tick is registered: high in the cycle the counter equals FRAME_LEN-1.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - ready is combinational from state, grant_id and the valid inputs.
  - At most one ready is high per cycle.
  - A requester may hold valid indefinitely; data must be stable while valid && !ready.
- FSM states: IDLE and RAMP.
- IDLE:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester ≠ grant_id gets ready=1.
  - On transfer: goal <= req_target, grant_id <= index, next state RAMP.
- RAMP:
  - Both ready=0, except under the Optional Feature.
  - Updates happen only in cycles with frame_tick=1.
  - Let d = |goal - target|, computed at 33-bit width, so there is no wrap.
  - If step==0 or d<=step: target <= goal, next state IDLE.
  - Else: target <= target+step if goal>target, otherwise target-step; stay in RAMP.
- Timing:
  - A transfer in the same cycle as frame_tick is not applied on that tick; the first update happens on the next frame_tick.
  - Minimum latency from transfer to `target` change is therefore 1..FRAME_LEN clocks.
  - goal==target on transfer: the next frame_tick returns the FSM to IDLE with `target` unchanged.
  - A new request may be accepted in the cycle after returning to IDLE.
- `step` is sampled on every frame_tick, so changing it mid-ramp takes effect at the next tick.
- `target` changes only on frame_tick edges or on reset.

Optional Feature:
- Macro: DSPMOD_TGT_PREEMPT_EN.
- Defined:
  - req0_ready is also asserted in RAMP whenever req0_valid=1; req0 has absolute priority there and req1 is never ready in RAMP.
  - On transfer: goal is replaced and grant_id=0; the ramp continues from the current `target` toward the new goal.
  - A transfer coinciding with frame_tick applies that tick's step toward the OLD goal; the new goal is used from the next tick.
- Undefined: no ready in RAMP, and behaviour is exactly as described above.

Test Plan:
- Reset / frame counter (FRAME_LEN=8, RESET_TARGET=100): release rst → target=100, busy=0, grant_id=1; frame_tick high exactly every 8 clks, first one 7 clks after release.
- Jump: step=0, req0 sends 5000 mid-frame → req0_ready 1 cycle, busy=1; target=5000 after the next frame_tick; busy=0 the following cycle.
- Ramp up: step=1000, target=100, req1 sends 3500 → target sequence 1100, 2100, 3100, 3500 on successive ticks, then IDLE. Ramp down from 3500 to 0 with step=1500 → 2000, 500, 0.
- Round-robin: both valid continuously with targets 10 and 20, step=0 → grants alternate 0,1,0,1; target alternates 10, 20 on frame boundaries; ready is never high for both.
- Reset mid-ramp: assert rst for 1 clk during a 100→3500 ramp → target=100 asynchronously, state IDLE, the pending goal is discarded.
- With DSPMOD_TGT_PREEMPT_EN: during a 0→10000 ramp with step=1000 and target=3000, req0 sends 1000 → next ticks give 2000, 1000, then IDLE. req1_valid held during the ramp is never readied.
